// File: rtl/sirv_axi_pkg.sv
// Shared encodings and state types for the AXI SRAM slave.
// The write and read channels each have their own state machine.
package sirv_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/sirv_axi_sram_slv_if.sv
// AXI bundle between a master and the SRAM slave.
// Clock and reset are kept as plain ports on the modules.
interface sirv_axi_sram_slv_if #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int LW = 4
);
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [LW-1:0] awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;

    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;

    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;

    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;

    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready
    );

endinterface

// File: rtl/sirv_axi_sram_slv_mem.sv
// DEPTH x DW storage with one byte-enabled write port and one registered read port.
// Kept separate so it can be swapped for a real SRAM macro.
module sirv_axi_sram_slv_mem #(
    parameter int DW    = 64,
    parameter int DEPTH = 1024,
    parameter int IW    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            re,
    input  logic            rclr,
    input  logic [IW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only enabled byte lanes change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // A same-cycle write to the read word is not visible until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rclr ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/sirv_axi_sram_slv.sv
// AXI slave backed by a byte-addressable register array with FIXED/INCR bursts,
// narrow transfers, per-beat SLVERR and independent read/write state machines.
module sirv_axi_sram_slv
    import sirv_axi_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int DEPTH = 1024,
    parameter int LW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sirv_axi_sram_slv_if.slave axi
);

    localparam int            OFFS     = $clog2(DW/8);
    localparam int            IW       = $clog2(DEPTH);
    localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
    localparam logic [2:0]    MAX_SIZE = 3'(OFFS);

    function automatic logic beat_err(input logic [AW-1:0] addr,
                                      input logic [2:0]    size,
                                      input logic [1:0]    burst);
        return !burst_supported(burst) || (size > MAX_SIZE) || ((addr >> OFFS) >= DEPTH_A);
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                                input logic [2:0]    size,
                                                input logic [1:0]    burst);
        return (burst == BURST_INCR) ? addr + (AW'(1) << size) : addr;
    endfunction

    w_state_e      w_state;
    logic [AW-1:0] w_addr;
    logic [LW-1:0] w_len;
    logic [LW-1:0] w_beat;
    logic [2:0]    w_size;
    logic [1:0]    w_burst;
    logic          w_err;
    logic          w_fire;
    logic          w_cur_err;
    logic          w_end_len;

    r_state_e      r_state;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_beat;
    logic [2:0]    r_size;
    logic [1:0]    r_burst;
    logic          ar_fire;
    logic          r_adv;
    logic [AW-1:0] rd_addr;
    logic          rd_err;

    assign w_fire    = (w_state == W_DATA) && axi.wvalid && axi.wready;
    assign w_cur_err = beat_err(w_addr, w_size, w_burst);
    assign w_end_len = (w_beat == w_len);

    assign ar_fire = (r_state == R_IDLE) && axi.arvalid && axi.arready;
    assign r_adv   = (r_state == R_DATA) && axi.rvalid && axi.rready && !axi.rlast;
    assign rd_addr = ar_fire ? axi.araddr : r_addr;
    assign rd_err  = ar_fire ? beat_err(axi.araddr, axi.arsize, axi.arburst)
                             : beat_err(r_addr, r_size, r_burst);

    sirv_axi_sram_slv_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_fire && !w_cur_err),
        .waddr (w_addr[OFFS +: IW]),
        .wdata (axi.wdata),
        .wstrb (axi.wstrb),
        .re    (ar_fire || r_adv),
        .rclr  (rd_err),
        .raddr (rd_addr[OFFS +: IW]),
        .rdata (axi.rdata)
    );

    // Burst ends on whichever of len-reached or wlast comes first; disagreement is an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_IDLE;
            axi.awready <= 1'b1;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= RESP_OKAY;
            w_addr      <= '0;
            w_len       <= '0;
            w_beat      <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_err       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi.awvalid) begin
                        w_addr      <= axi.awaddr;
                        w_len       <= axi.awlen;
                        w_size      <= axi.awsize;
                        w_burst     <= axi.awburst;
                        w_beat      <= '0;
                        w_err       <= 1'b0;
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b1;
                        w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_end_len || axi.wlast) begin
                            axi.wready <= 1'b0;
                            axi.bvalid <= 1'b1;
                            axi.bresp  <= (w_err || w_cur_err || (w_end_len != axi.wlast))
                                          ? RESP_SLVERR : RESP_OKAY;
                            w_state    <= W_RESP;
                        end else begin
                            w_err  <= w_err | w_cur_err;
                            w_beat <= w_beat + LW'(1);
                            w_addr <= next_addr(w_addr, w_size, w_burst);
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        axi.bvalid  <= 1'b0;
                        axi.bresp   <= RESP_OKAY;
                        axi.awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // r_addr always holds the address of the beat to be fetched on the next advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            axi.arready <= 1'b1;
            axi.rvalid  <= 1'b0;
            axi.rlast   <= 1'b0;
            axi.rresp   <= RESP_OKAY;
            r_addr      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_size      <= '0;
            r_burst     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_addr      <= next_addr(axi.araddr, axi.arsize, axi.arburst);
                        r_len       <= axi.arlen;
                        r_size      <= axi.arsize;
                        r_burst     <= axi.arburst;
                        r_beat      <= '0;
                        axi.arready <= 1'b0;
                        axi.rvalid  <= 1'b1;
                        axi.rlast   <= (axi.arlen == '0);
                        axi.rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rvalid && axi.rready) begin
                        if (axi.rlast) begin
                            axi.rvalid  <= 1'b0;
                            axi.rlast   <= 1'b0;
                            axi.rresp   <= RESP_OKAY;
                            axi.arready <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_beat    <= r_beat + LW'(1);
                            axi.rlast <= ((r_beat + LW'(1)) == r_len);
                            axi.rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
                            r_addr    <= next_addr(r_addr, r_size, r_burst);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sirv_axi_sram_slv.sv
// Randomised and directed bench for sirv_axi_sram_slv against a word-array
// reference model that computes each beat's address and error from first principles.
module tb_sirv_axi_sram_slv;
    import sirv_axi_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int LW    = 4;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sirv_axi_sram_slv_if #(.AW(AW), .DW(DW), .LW(LW)) axi ();

    sirv_axi_sram_slv #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (axi)
    );

    logic [63:0] modelMem [DEPTH];
    logic [63:0] wrData [16];
    logic [7:0]  wrStrb [16];
    logic [63:0] rdBuf [16];
    logic [1:0]  lastBresp;
    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Address of beat i computed directly from the start address.
    function automatic logic [31:0] beatAddr(input logic [31:0] start, input logic [2:0] size,
                                             input logic [1:0] burst, input int i);
        if (burst == 2'b01) return start + 32'(i) * (32'd1 << size);
        return start;
    endfunction

    function automatic logic beatBad(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        return (burst > 2'b01) || (size > 3'd3) || ((a >> 3) >= 32'(DEPTH));
    endfunction

    task automatic waitHigh(input string tag, ref logic sig);
        int cnt = 0;
        while (sig !== 1'b1 && cnt < LIMIT) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput(tag, 64'(sig), 64'd1);
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int wlastIdx);
        int nb;
        logic expErr;
        logic [31:0] a;
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awsize  = size;
        axi.awburst = burst;
        axi.awvalid = 1'b1;
        waitHigh("awready", axi.awready);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        checkOutput("wready_lat", 64'(axi.wready), 64'd1);
        nb = (wlastIdx >= 0 && wlastIdx < int'(len)) ? wlastIdx + 1 : int'(len) + 1;
        expErr = (wlastIdx != int'(len));
        for (int i = 0; i < nb; i++) begin
            axi.wvalid = 1'b1;
            axi.wdata  = wrData[i];
            axi.wstrb  = wrStrb[i];
            axi.wlast  = (i == wlastIdx);
            waitHigh("wready", axi.wready);
            @(posedge clk); #1;
            axi.wvalid = 1'b0;
            axi.wlast  = 1'b0;
            a = beatAddr(addr, size, burst, i);
            if (beatBad(a, size, burst)) begin
                expErr = 1'b1;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (wrStrb[i][b]) modelMem[a >> 3][b*8 +: 8] = wrData[i][b*8 +: 8];
                end
            end
            if (i == nb - 1) begin
                checkOutput("bvalid_lat", 64'(axi.bvalid), 64'd1);
            end else begin
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        waitHigh("bvalid", axi.bvalid);
        checkOutput("bresp", 64'(axi.bresp), expErr ? 64'd2 : 64'd0);
        lastBresp = axi.bresp;
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        checkOutput("awready_ret", 64'(axi.awready), 64'd1);
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int stallBeat, input int stallCycles);
        logic [31:0] a;
        logic [63:0] expData;
        logic        bad;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        waitHigh("arready", axi.arready);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        checkOutput("rvalid_lat", 64'(axi.rvalid), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            waitHigh("rvalid", axi.rvalid);
            a = beatAddr(addr, size, burst, i);
            bad = beatBad(a, size, burst);
            expData = bad ? 64'd0 : modelMem[a >> 3];
            if (i == stallBeat) begin
                repeat (stallCycles) begin
                    checkOutput("rdata_hold", axi.rdata, expData);
                    @(posedge clk); #1;
                end
            end
            checkOutput("rdata", axi.rdata, expData);
            checkOutput("rresp", 64'(axi.rresp), bad ? 64'd2 : 64'd0);
            checkOutput("rlast", 64'(axi.rlast), (i == int'(len)) ? 64'd1 : 64'd0);
            rdBuf[i] = axi.rdata;
            axi.rready = 1'b1;
            @(posedge clk); #1;
            axi.rready = 1'b0;
            if (i < int'(len)) begin
                checkOutput("rvalid_next", 64'(axi.rvalid), 64'd1);
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
        end
        checkOutput("arready_ret", 64'(axi.arready), 64'd1);
    endtask

    task automatic fillStrobes(input logic [7:0] s);
        for (int i = 0; i < 16; i++) wrStrb[i] = s;
    endtask

    // Random bursts of mixed size, type and address, each followed by a readback.
    task automatic applyStimulus(input int iterations);
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int r;
        for (int n = 0; n < iterations; n++) begin
            r = $urandom_range(0, 9);
            size = (r < 6) ? 3'd3 : (r < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 7));
            r = $urandom_range(0, 9);
            burst = (r < 6) ? 2'b01 : (r < 9) ? 2'b00 : 2'($urandom_range(2, 3));
            r = $urandom_range(0, 9);
            addr = (r < 8) ? 32'($urandom_range(0, DEPTH*8 - 1))
                           : 32'($urandom_range(DEPTH*8 - 64, DEPTH*8 + 64));
            len = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                wrData[i] = {$urandom, $urandom};
                wrStrb[i] = 8'($urandom_range(0, 255));
            end
            writeBurst(addr, len, size, burst, int'(len));
            readBurst(addr, len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), -1, 0);
        end
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0; axi.wlast  = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.rready  = 1'b0;
        lastBresp   = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_awready", 64'(axi.awready), 64'd1);
        checkOutput("rst_arready", 64'(axi.arready), 64'd1);
        checkOutput("rst_wready",  64'(axi.wready),  64'd0);
        checkOutput("rst_bvalid",  64'(axi.bvalid),  64'd0);
        checkOutput("rst_bresp",   64'(axi.bresp),   64'd0);
        checkOutput("rst_rvalid",  64'(axi.rvalid),  64'd0);
        checkOutput("rst_rlast",   64'(axi.rlast),   64'd0);
        checkOutput("rst_rresp",   64'(axi.rresp),   64'd0);
        checkOutput("rst_rdata",   axi.rdata,        64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] filling memory");
        fillStrobes(8'hFF);
        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int i = 0; i < 16; i++) wrData[i] = {$urandom, $urandom};
            writeBurst(32'(k * 128), 4'd15, 3'd3, 2'b01, 15);
        end

        $display("[TB] directed: single beat");
        wrData[0] = 64'h1122334455667788;
        writeBurst(32'h10, 4'd0, 3'd3, 2'b01, 0);
        checkOutput("t1_bresp", 64'(lastBresp), 64'd0);
        readBurst(32'h10, 4'd0, 3'd3, 2'b01, -1, 0);
        checkOutput("t1_rdata", rdBuf[0], 64'h1122334455667788);

        $display("[TB] directed: INCR and FIXED");
        for (int i = 0; i < 4; i++) wrData[i] = 64'(i + 1);
        writeBurst(32'h0, 4'd3, 3'd3, 2'b01, 3);
        readBurst(32'h0, 4'd3, 3'd3, 2'b01, -1, 0);
        checkOutput("incr_w0", rdBuf[0], 64'd1);
        checkOutput("incr_w3", rdBuf[3], 64'd4);
        wrData[0] = 64'hA; wrData[1] = 64'hB; wrData[2] = 64'hC; wrData[3] = 64'hD;
        writeBurst(32'h8, 4'd3, 3'd3, 2'b00, 3);
        readBurst(32'h8, 4'd1, 3'd3, 2'b00, -1, 0);
        checkOutput("fixed_b0", rdBuf[0], 64'hD);
        checkOutput("fixed_b1", rdBuf[1], 64'hD);

        $display("[TB] directed: strobes");
        wrData[0] = '1;
        writeBurst(32'h20, 4'd0, 3'd3, 2'b01, 0);
        wrData[0] = '0;
        wrStrb[0] = 8'h0F;
        writeBurst(32'h20, 4'd0, 3'd3, 2'b01, 0);
        readBurst(32'h20, 4'd0, 3'd3, 2'b01, -1, 0);
        checkOutput("strb_word", rdBuf[0], 64'hFFFFFFFF00000000);
        fillStrobes(8'hFF);

        $display("[TB] directed: errors");
        wrData[0] = 64'h5555; wrData[1] = 64'h6666;
        writeBurst(32'(DEPTH * 8), 4'd1, 3'd3, 2'b01, 1);
        checkOutput("oob_bresp", 64'(lastBresp), 64'd2);
        readBurst(32'(DEPTH * 8), 4'd1, 3'd3, 2'b01, -1, 0);
        checkOutput("oob_rdata1", rdBuf[1], 64'd0);
        writeBurst(32'h40, 4'd3, 3'd3, 2'b01, 1);
        checkOutput("early_wlast", 64'(lastBresp), 64'd2);
        writeBurst(32'h60, 4'd2, 3'd3, 2'b01, -1);
        checkOutput("missing_wlast", 64'(lastBresp), 64'd2);
        writeBurst(32'h80, 4'd1, 3'd3, 2'b10, 1);
        checkOutput("bad_burst", 64'(lastBresp), 64'd2);
        writeBurst(32'h80, 4'd0, 3'd4, 2'b01, 0);
        checkOutput("bad_size", 64'(lastBresp), 64'd2);
        readBurst(32'h40, 4'd7, 3'd3, 2'b01, -1, 0);

        $display("[TB] directed: read backpressure");
        readBurst(32'h0, 4'd3, 3'd3, 2'b01, 1, 5);

        $display("[TB] directed: reset during write data");
        axi.awaddr = 32'h200; axi.awlen = 4'd3; axi.awsize = 3'd3; axi.awburst = 2'b01;
        axi.awvalid = 1'b1;
        waitHigh("rw_awready", axi.awready);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.wvalid = 1'b1; axi.wdata = 64'hC0DE_0000 + 64'(i); axi.wstrb = 8'hFF; axi.wlast = 1'b0;
            waitHigh("rw_wready", axi.wready);
            @(posedge clk); #1;
            modelMem[(32'h200 >> 3) + i] = 64'hC0DE_0000 + 64'(i);
        end
        axi.wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rw_wready_low", 64'(axi.wready), 64'd0);
        checkOutput("rw_awready_hi", 64'(axi.awready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rw_wready_rel", 64'(axi.wready), 64'd0);
        checkOutput("rw_awready_rel", 64'(axi.awready), 64'd1);
        checkOutput("rw_bvalid_rel", 64'(axi.bvalid), 64'd0);
        for (int i = 0; i < 4; i++) wrData[i] = 64'hBEEF_0000 + 64'(i);
        writeBurst(32'h300, 4'd3, 3'd3, 2'b01, 3);
        checkOutput("rw_next_okay", 64'(lastBresp), 64'd0);
        readBurst(32'h200, 4'd3, 3'd3, 2'b01, -1, 0);
        checkOutput("rw_kept_b1", rdBuf[1], 64'hC0DE_0001);

        $display("[TB] random bursts");
        applyStimulus(40);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
